// File: rtl/serial_bcd_alu_n_if.sv
// Serial BCD ALU frame port: input bit stream,
// registered result stream and busy/done status.
interface serial_bcd_alu_n_if;
  logic din;
  logic result;
  logic busy;
  logic done;

  modport master (
    output din,
    input  result,
    input  busy,
    input  done
  );

  modport slave (
    input  din,
    output result,
    output busy,
    output done
  );
endinterface

// File: rtl/serial_bcd_alu_n.sv
// Digit-serial BCD add / signed subtract with sync-framed
// serial input and header-framed serial result.
module serial_bcd_alu_n #(
  parameter int          DIGITS    = 4,
  parameter logic [7:0]  SYNC_WORD = 8'h5A,
  parameter logic [7:0]  HDR_WORD  = 8'h69
) (
  input  logic clock,
  input  logic reset,
  serial_bcd_alu_n_if.slave bus
);

  localparam int W  = 4 * DIGITS;
  localparam int RW = W + 4;
  localparam int F  = 10 + RW;

  localparam logic [5:0] C_LD = 6'(W - 1);
  localparam logic [5:0] C_DG = 6'(DIGITS - 1);
  localparam logic [5:0] C_TX = 6'(F);

  typedef enum logic [2:0] {
    S_HUNT,
    S_OPCODE,
    S_LOAD_A,
    S_LOAD_B,
    S_CALC,
    S_NEG,
    S_TX
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [7:0]    r_hist;
  logic          r_op;
  logic          r_carry;
  logic          r_err;
  logic          r_sign;
  logic          r_res;
  logic          r_done;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_sum;
  logic [5:0]    r_cnt;

  logic [7:0]    w_hist;
  logic          w_match;
  logic [3:0]    w_x;
  logic [3:0]    w_y;
  logic [3:0]    w_yc;
  logic          w_cin;
  logic [4:0]    w_s;
  logic          w_gt;
  logic [3:0]    w_dig;
  logic          w_bad;
  logic          w_last;
  logic [W-1:0]  w_arot;
  logic [W-1:0]  w_brot;
  logic [W-1:0]  w_snext;
  logic [3:0]    w_top;
  logic [RW-1:0] w_rd;
  logic [63:0]   w_frame;

  assign w_hist  = {bus.din, r_hist[7:1]};
  assign w_match = (w_hist == SYNC_WORD);

  // NEG pass swaps operands to form B-A
  assign w_x   = (r_state == S_NEG) ? r_b[3:0] : r_a[3:0];
  assign w_y   = (r_state == S_NEG) ? r_a[3:0] : r_b[3:0];
  assign w_yc  = r_op ? (4'd9 - w_y) : w_y;
  assign w_cin = (r_cnt == 6'd0) ? r_op : r_carry;
  assign w_s   = {1'b0, w_x} + {1'b0, w_yc} + {4'd0, w_cin};
  assign w_gt  = (w_s > 5'd9);
  assign w_dig = w_gt ? (w_s[3:0] + 4'd6) : w_s[3:0];
  assign w_bad = (r_a[3:0] > 4'd9) || (r_b[3:0] > 4'd9);
  assign w_last = (r_cnt == C_DG);

  assign w_arot  = (r_a >> 4) | (W'(r_a[3:0]) << (W - 4));
  assign w_brot  = (r_b >> 4) | (W'(r_b[3:0]) << (W - 4));
  assign w_snext = (r_sum >> 4) | (W'(w_dig) << (W - 4));

  assign w_top = r_op ? 4'd0 : {3'd0, r_carry};
  assign w_rd  = r_err ? '0 : {w_top, r_sum};

  always_comb begin
    w_frame = '0;
    for (int i = 0; i < 8; i++) begin
      w_frame[i] = HDR_WORD[i];
    end
    w_frame[8] = r_sign & ~r_err;
    w_frame[9] = r_err;
    for (int j = 0; j < RW; j++) begin
      w_frame[10+j] = w_rd[RW-1-j];
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_HUNT:   if (w_match) w_next = S_OPCODE;
      S_OPCODE: w_next = S_LOAD_A;
      S_LOAD_A: if (r_cnt == C_LD) w_next = S_LOAD_B;
      S_LOAD_B: if (r_cnt == C_LD) w_next = S_CALC;
      S_CALC: begin
        if (w_last) begin
          if (r_op && !w_gt && !(r_err || w_bad)) begin
            w_next = S_NEG;
          end else begin
            w_next = S_TX;
          end
        end
      end
      S_NEG:    if (w_last) w_next = S_TX;
      S_TX:     if (r_cnt == C_TX) w_next = S_HUNT;
      default:  w_next = S_HUNT;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_HUNT;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_hist  <= '0;
      r_op    <= 1'b0;
      r_carry <= 1'b0;
      r_err   <= 1'b0;
      r_sign  <= 1'b0;
      r_res   <= 1'b0;
      r_done  <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
    end else begin
      r_cnt  <= (w_next != r_state) ? 6'd0 : r_cnt + 6'd1;
      r_res  <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_HUNT: r_hist <= w_match ? 8'd0 : w_hist;
        S_OPCODE: begin
          r_op   <= bus.din;
          r_err  <= 1'b0;
          r_sign <= 1'b0;
        end
        S_LOAD_A: r_a <= {r_a[W-2:0], bus.din};
        S_LOAD_B: r_b <= {r_b[W-2:0], bus.din};
        S_CALC, S_NEG: begin
          r_a     <= w_arot;
          r_b     <= w_brot;
          r_sum   <= w_snext;
          r_carry <= w_gt;
          if (r_state == S_CALC) r_err <= r_err | w_bad;
          if (w_next == S_NEG) r_sign <= 1'b1;
        end
        S_TX: begin
          r_res  <= w_frame[r_cnt];
          r_done <= (r_cnt == C_TX - 6'd1);
        end
        default: ;
      endcase
    end
  end

  assign bus.result = r_res;
  assign bus.done   = r_done;
  assign bus.busy   = (r_state != S_HUNT) && (r_state != S_OPCODE);

endmodule

// File: tb/tb_serial_bcd_alu_n.sv
// Bench for serial_bcd_alu_n: DIGITS = 4, 1 and 8 instances,
// decimal reference model with an expected-frame queue.
module tb_serial_bcd_alu_n;

  typedef struct {
    int          sel;
    logic [63:0] bits;
    int          len;
    int          lat;
    int          t_last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  din = 3'b000;
  logic [2:0]  res;
  logic [2:0]  busy;
  logic [2:0]  done;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          n_tx = 0;
  int          n_rx = 0;
  exp_t        q[$];
  logic [63:0] hist [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_bcd_alu_n_if u_if0 ();
  serial_bcd_alu_n_if u_if1 ();
  serial_bcd_alu_n_if u_if2 ();

  assign u_if0.din = din[0];
  assign u_if1.din = din[1];
  assign u_if2.din = din[2];
  assign res  = {u_if2.result, u_if1.result, u_if0.result};
  assign busy = {u_if2.busy, u_if1.busy, u_if0.busy};
  assign done = {u_if2.done, u_if1.done, u_if0.done};

  serial_bcd_alu_n #(.DIGITS(4)) u_dut0 (
    .clock (clk),
    .reset (rst_n),
    .bus   (u_if0)
  );
  serial_bcd_alu_n #(.DIGITS(1)) u_dut1 (
    .clock (clk),
    .reset (rst_n),
    .bus   (u_if1)
  );
  serial_bcd_alu_n #(.DIGITS(8)) u_dut2 (
    .clock (clk),
    .reset (rst_n),
    .bus   (u_if2)
  );

  function automatic int dg(int s);
    return (s == 0) ? 4 : ((s == 1) ? 1 : 8);
  endfunction

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(int s, logic op, logic [31:0] a,
                                 logic [31:0] b, int t);
    exp_t       e;
    int         d;
    logic       err;
    logic       sign;
    longint     av;
    longint     bv;
    longint     r;
    int         dd [9];
    logic [7:0] hdr;
    logic [3:0] nib;
    d = dg(s);
    err = 1'b0;
    av = 0;
    bv = 0;
    for (int i = d - 1; i >= 0; i--) begin
      nib = a[4*i +: 4];
      if (nib > 4'd9) err = 1'b1;
      av = av * 10 + longint'(nib);
      nib = b[4*i +: 4];
      if (nib > 4'd9) err = 1'b1;
      bv = bv * 10 + longint'(nib);
    end
    r = 0;
    sign = 1'b0;
    e.lat = d + 1;
    if (!err) begin
      if (!op) r = av + bv;
      else if (av >= bv) r = av - bv;
      else begin
        r = bv - av;
        sign = 1'b1;
        e.lat = 2 * d + 1;
      end
    end
    for (int k = 0; k <= d; k++) begin
      dd[k] = int'(r % 10);
      r = r / 10;
    end
    e.bits = '0;
    hdr = 8'h69;
    for (int i = 0; i < 8; i++) e.bits = {e.bits[62:0], hdr[i]};
    e.bits = {e.bits[62:0], sign};
    e.bits = {e.bits[62:0], err};
    for (int k = d; k >= 0; k--) begin
      nib = 4'(dd[k]);
      for (int bi = 3; bi >= 0; bi--) e.bits = {e.bits[62:0], nib[bi]};
    end
    e.len = 10 + 4 * (d + 1);
    e.sel = s;
    e.t_last = t;
    return e;
  endfunction

  task automatic put(int s, logic b);
    @(negedge clk);
    din[s] = b;
  endtask

  task automatic idle(int s, int n);
    repeat (n) put(s, 1'b0);
  endtask

  task automatic send(int s, logic op, logic [31:0] a,
                      logic [31:0] b, bit push);
    logic [7:0] sw;
    int d;
    sw = 8'h5A;
    d = dg(s);
    for (int i = 0; i < 8; i++) put(s, sw[i]);
    put(s, op);
    for (int i = 4 * d - 1; i >= 0; i--) put(s, a[i]);
    for (int i = 4 * d - 1; i >= 0; i--) put(s, b[i]);
    if (push) begin
      q.push_back(model(s, op, a, b, cyc + 1));
      n_tx++;
    end
  endtask

  task automatic drain(int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      check("timeout", 64'(q.size()), 64'd0);
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    exp_t e;
    for (int s = 0; s < 3; s++) hist[s] = '0;
    forever begin
      @(negedge clk);
      for (int s = 0; s < 3; s++) begin
        hist[s] = {hist[s][62:0], res[s]};
        if (done[s] === 1'b1) begin
          n_rx++;
          if (q.size() > 0) begin
            e = q.pop_front();
            check("sel", 64'(s), 64'(e.sel));
            check("frame", hist[s] & ((64'd1 << e.len) - 64'd1), e.bits);
            check("latency", 64'(cyc - e.t_last), 64'(e.lat + e.len - 1));
          end
        end
      end
    end
  end

  initial begin
    logic [12:0] junk;
    logic [7:0]  sw;
    int          tl;
    junk = 13'b1101011110011;
    sw = 8'h5A;
    repeat (3) @(negedge clk);
    check("rst_result", 64'(res), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    send(0, 1'b0, 32'h1234, 32'h5678, 1'b1); idle(0, 1); drain(100);
    send(0, 1'b1, 32'h5000, 32'h0001, 1'b1); idle(0, 1); drain(100);
    send(0, 1'b1, 32'h0001, 32'h0002, 1'b1); idle(0, 1); drain(100);
    send(0, 1'b0, 32'h9999, 32'h9999, 1'b1); idle(0, 1); drain(100);
    send(0, 1'b1, 32'h4321, 32'h4321, 1'b1); idle(0, 1); drain(100);
    send(0, 1'b0, 32'h12A4, 32'h1111, 1'b1); idle(0, 1); drain(100);

    for (int i = 12; i >= 0; i--) put(0, junk[i]);
    send(0, 1'b0, 32'h0042, 32'h0958, 1'b1); idle(0, 1); drain(100);

    send(0, 1'b1, 32'h0300, 32'h0050, 1'b1);
    idle(0, 8);
    for (int i = 0; i < 8; i++) put(0, sw[i]);
    idle(0, 1);
    drain(100);

    send(0, 1'b0, 32'h1234, 32'h5678, 1'b0);
    tl = cyc + 1;
    idle(0, 1);
    while (cyc < tl + 5 + 12) @(negedge clk);
    check("tx_busy", 64'(busy[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_result", 64'(res[0]), 64'd0);
    check("abort_busy", 64'(busy[0]), 64'd0);
    @(negedge clk);
    check("abort_done", 64'(done[0]), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send(0, 1'b1, 32'h0815, 32'h4711, 1'b1); idle(0, 1); drain(100);

    send(1, 1'b0, 32'h7, 32'h5, 1'b1); idle(1, 1); drain(100);
    send(1, 1'b1, 32'h3, 32'h8, 1'b1); idle(1, 1); drain(100);

    send(2, 1'b0, 32'h12345678, 32'h87654321, 1'b1); idle(2, 1); drain(200);
    send(2, 1'b0, 32'h99999999, 32'h00000001, 1'b1); idle(2, 1); drain(200);
    send(2, 1'b1, 32'h10000000, 32'h20000000, 1'b1); idle(2, 1); drain(200);

    repeat (60) @(negedge clk);
    check("frames", 64'(n_rx), 64'(n_tx));
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=%0d exp=%0d", n_rx, n_tx);
    $fatal(1, "bench did not complete");
  end

endmodule

// File: doc/serial_bcd_alu_n.md
Name: serial_bcd_alu_n

Overview:
Parametrised successor of the serial BCD add/subtract block. It takes a 1-bit serial frame on din: sync word, opcode, A operand (DIGITS BCD digits), B operand (DIGITS BCD digits). It computes A+B or a signed A−B digit-serially, one digit per clock, and returns a serial result frame on result. Compared with the previous generation it adds:
- operand width set by parameter
- signed subtraction (sign-magnitude result)
- invalid-digit detection
- busy/done status

Parameters:
DIGITS, 4, BCD digits per operand (legal 1..8)
SYNC_WORD, 8'h5A, input sync pattern, received LSB first
HDR_WORD, 8'h69, output header, transmitted LSB first

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset)
din  input  1  serial input bit, sampled every rising edge
result  output  1  serial output bit, registered
busy  output  1  high from opcode capture to end of transmit
done  output  1  one-cycle pulse, coincident with last result bit

Behaviour:
- Reset (reset=0, async): FSM→HUNT; sync history, operand, result and TX registers cleared; result=0, busy=0, done=0. Reset mid-frame, mid-compute or mid-transmit aborts with no partial output.
- States: HUNT → OPCODE → LOAD_A → LOAD_B → CALC → (NEG) → TX → HUNT.
- HUNT: shift din into 8-bit history, newest bit at MSB. On the edge where history equals SYNC_WORD (time order 0,1,0,1,1,0,1,0), go to OPCODE.
- OPCODE: the next sampled bit is op (0=add, 1=sub). busy=1 from the following cycle.
- LOAD_A, LOAD_B: 4*DIGITS bits each. Most-significant digit first, each digit MSB first.
- din is ignored from CALC until TX completes. Sync words arriving then are dropped.
- History is cleared on entering OPCODE, so payload bits never combine with earlier bits to form a sync match.
- CALC: DIGITS cycles, least-significant digit first, 1-bit decimal carry/borrow register.
  - Add: per digit s=a+b+c; if s>9 then digit=s+6 (low 4 bits), carry=1.
  - Sub: nine's complement of b, initial carry 1.
  - Any A or B nibble >9 sets err.
- NEG: entered only for op=sub with final carry 0 and err=0, meaning A<B. Re-runs CALC for B−A over DIGITS cycles and sets sign=1.
- Result register has DIGITS+1 digits:
  - add: top digit = final carry (0 or 1)
  - sub: top digit = 0
  - err=1: all digits 0 and sign=0
- TX frame, 10+4*(DIGITS+1) bits, in order:
  - HDR_WORD LSB first
  - sign
  - err
  - result digits, most-significant first, each MSB first
- done=1 on the cycle the last bit is on result. Next cycle: result=0, busy=0, state HUNT.
- Latency is counted from the edge sampling the last B bit to the first header bit on result:
  - DIGITS+1 cycles for add, non-negative sub, or err
  - 2*DIGITS+1 cycles for negative sub
- result=0 whenever not in TX.
- Back-to-back frames: a new sync may start the cycle after done.

Test Plan:
- DIGITS=4, op=0, A=1234, B=5678 → header 1,0,0,1,0,1,1,0; sign=0; err=0; digits 0,6,9,1,2; done on bit 30; latency 5.
- op=1, A=5000, B=0001 → sign=0, digits 0,4,9,9,9; A=0001, B=0002 → sign=1, digits 0,0,0,0,1, latency 9.
- op=0, A=9999, B=9999 → digits 1,9,9,9,8. op=1, A=B=4321 → sign=0, all digits 0.
- A=12A4 (nibble 1010), op=0 → err=1, sign=0, digits all 0, normal latency.
- 13 junk bits containing partial sync 0,1,0,1,1, then a full frame → exactly one result frame. A second sync sent during TX is ignored.
- Assert reset during TX bit 12 → result=0 and busy=0 immediately. After release, a fresh frame gives the correct result. Repeat the add case with DIGITS=1 (7+5 → 1,2) and DIGITS=8.
